// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter that shares one SRAM-like memory port between instruction fetch and data access.
// One transaction is outstanding at a time. A fetch killed by a pipeline flush is completed downstream but hidden from the core.
module cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_flush,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              inst_on,
  output logic              data_on,
  output logic              protocol_err
);

  typedef enum logic [2:0] {IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT} state_t;

  state_t state;
  logic   lastGrant;
  logic   discard;
  logic   instReqLive;
  logic   instBusy;
  logic   dataBusy;

  // A fetch raised in the same cycle as a flush is already stale.
  assign instReqLive = inst_req & ~inst_flush;
  assign instBusy    = (state == I_ADDR) || (state == I_WAIT);
  assign dataBusy    = (state == D_ADDR) || (state == D_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lastGrant    <= 1'b0;
      discard      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (mem_data_ok && (state == IDLE || state == I_ADDR || state == D_ADDR))
        protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (data_req && instReqLive)
            state <= lastGrant ? I_ADDR : D_ADDR;
          else if (data_req)
            state <= D_ADDR;
          else if (instReqLive)
            state <= I_ADDR;
        end
        I_ADDR: begin
          if (mem_addr_ok) begin
            state     <= I_WAIT;
            lastGrant <= 1'b0;
            discard   <= inst_flush;
          end else if (inst_flush) begin
            state <= IDLE;
          end
        end
        I_WAIT: begin
          if (mem_data_ok) begin
            state   <= IDLE;
            discard <= 1'b0;
          end else if (inst_flush) begin
            discard <= 1'b1;
          end
        end
        D_ADDR: begin
          if (mem_addr_ok) begin
            state     <= D_WAIT;
            lastGrant <= 1'b1;
          end
        end
        D_WAIT: begin
          if (mem_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    case (state)
      I_ADDR: begin
        mem_req      = 1'b1;
        mem_size     = 2'd2;
        mem_addr     = inst_addr;
        inst_addr_ok = mem_addr_ok;
      end
      I_WAIT: begin
        inst_data_ok = mem_data_ok & ~discard & ~inst_flush;
        if (inst_data_ok)
          inst_rdata = mem_rdata;
      end
      D_ADDR: begin
        mem_req      = 1'b1;
        mem_wr       = data_wr;
        mem_size     = data_size;
        mem_addr     = data_addr;
        mem_wdata    = data_wdata;
        data_addr_ok = mem_addr_ok;
      end
      D_WAIT: begin
        data_data_ok = mem_data_ok;
        if (mem_data_ok)
          data_rdata = mem_rdata;
      end
      default: ;
    endcase
    // Busy flags release in the data_ok cycle so the stalled stage advances with the data.
    inst_on = ~inst_flush & ~inst_data_ok & (inst_req | (instBusy & ~discard));
    data_on = ~data_data_ok & (data_req | dataBusy);
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: data-side vector table, directed fetch/flush/contention sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_flush, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        inst_on, data_on, protocol_err;

  int checks = 0;
  int errors = 0;

  cpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_flush(inst_flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata),
    .inst_on(inst_on), .data_on(data_on), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        aok, dok;
    logic [31:0] rdata;
    logic        eReq, eWr;
    logic [1:0]  eSize;
    logic [31:0] eAddr, eWdata;
    logic        eAok, eDok;
    logic [31:0] eRdata;
    logic        eOn, eErr;
  } vec_t;

  localparam logic        L  = 1'b0;
  localparam logic        H  = 1'b1;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] LA = 32'h8000_0010;
  localparam logic [31:0] SA = 32'h0000_1234;
  localparam logic [31:0] SW = 32'h0000_00AB;
  localparam logic [31:0] RA = 32'h0000_0040;

  vec_t tbl[24];

  function automatic vec_t mkv(
    input logic r, q, w, input logic [1:0] s, input logic [31:0] a, wd,
    input logic ao, dk, input logic [31:0] rd,
    input logic eq, ew, input logic [1:0] es, input logic [31:0] ea, ewd,
    input logic eao, edk, input logic [31:0] erd, input logic eon, eer);
    vec_t v;
    v.rst = r; v.req = q; v.wr = w; v.size = s; v.addr = a; v.wdata = wd;
    v.aok = ao; v.dok = dk; v.rdata = rd;
    v.eReq = eq; v.eWr = ew; v.eSize = es; v.eAddr = ea; v.eWdata = ewd;
    v.eAok = eao; v.eDok = edk; v.eRdata = erd; v.eOn = eon; v.eErr = eer;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    inst_req = 1'b0; inst_addr = '0; inst_flush = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  task automatic doReset();
    applyIdle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic runTable();
    tbl[0]  = mkv(L,H,L,2'd2,LA,Z,L,L,Z,            L,L,2'd0,Z,Z,L,L,Z,H,L);
    tbl[1]  = mkv(L,H,L,2'd2,LA,Z,L,L,Z,            H,L,2'd2,LA,Z,L,L,Z,H,L);
    tbl[2]  = mkv(L,H,L,2'd2,LA,Z,H,L,Z,            H,L,2'd2,LA,Z,H,L,Z,H,L);
    tbl[3]  = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,H,L);
    tbl[4]  = mkv(L,L,L,2'd0,Z,Z,L,H,32'hDEADBEEF,  L,L,2'd0,Z,Z,L,H,32'hDEADBEEF,L,L);
    tbl[5]  = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,L,L);
    tbl[6]  = mkv(L,H,H,2'd0,SA,SW,L,L,Z,           L,L,2'd0,Z,Z,L,L,Z,H,L);
    for (int i = 7; i <= 11; i++)
      tbl[i] = mkv(L,H,H,2'd0,SA,SW,L,L,Z,          H,H,2'd0,SA,SW,L,L,Z,H,L);
    tbl[12] = mkv(L,H,H,2'd0,SA,SW,H,L,Z,           H,H,2'd0,SA,SW,H,L,Z,H,L);
    tbl[13] = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,H,L);
    tbl[14] = mkv(L,L,L,2'd0,Z,Z,L,H,32'h12345678,  L,L,2'd0,Z,Z,L,H,32'h12345678,L,L);
    tbl[15] = mkv(L,L,L,2'd0,Z,Z,L,H,32'h55555555,  L,L,2'd0,Z,Z,L,L,Z,L,L);
    tbl[16] = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,L,H);
    tbl[17] = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,L,H);
    tbl[18] = mkv(L,H,L,2'd2,RA,Z,L,L,Z,            L,L,2'd0,Z,Z,L,L,Z,H,H);
    tbl[19] = mkv(L,H,L,2'd2,RA,Z,L,L,Z,            H,L,2'd2,RA,Z,L,L,Z,H,H);
    tbl[20] = mkv(L,H,L,2'd2,RA,Z,H,L,Z,            H,L,2'd2,RA,Z,H,L,Z,H,H);
    tbl[21] = mkv(H,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,H,H);
    tbl[22] = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,L,L);
    tbl[23] = mkv(L,L,L,2'd0,Z,Z,L,L,Z,             L,L,2'd0,Z,Z,L,L,Z,L,L);
    for (int i = 0; i < 24; i++) begin
      applyIdle();
      rst = tbl[i].rst; data_req = tbl[i].req; data_wr = tbl[i].wr; data_size = tbl[i].size;
      data_addr = tbl[i].addr; data_wdata = tbl[i].wdata;
      mem_addr_ok = tbl[i].aok; mem_data_ok = tbl[i].dok; mem_rdata = tbl[i].rdata;
      #3;
      chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].eReq);
      chk($sformatf("tbl%0d_mem_wr", i), mem_wr, tbl[i].eWr);
      chk($sformatf("tbl%0d_mem_size", i), mem_size, tbl[i].eSize);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].eAddr);
      chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].eWdata);
      chk($sformatf("tbl%0d_data_addr_ok", i), data_addr_ok, tbl[i].eAok);
      chk($sformatf("tbl%0d_data_data_ok", i), data_data_ok, tbl[i].eDok);
      chk($sformatf("tbl%0d_data_rdata", i), data_rdata, tbl[i].eRdata);
      chk($sformatf("tbl%0d_data_on", i), data_on, tbl[i].eOn);
      chk($sformatf("tbl%0d_protocol_err", i), protocol_err, tbl[i].eErr);
      step();
    end
    rst = 1'b0;
    applyIdle();
  endtask

  task automatic runContention();
    bit pendData = 1'b0;
    bit expData;
    int grants = 0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    data_req = 1'b1; data_addr = 32'h8000_0100; data_wr = 1'b0; data_size = 2'd2;
    mem_addr_ok = 1'b1;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      mem_data_ok = pendData;
      mem_rdata = 32'h0;
      pendData = 1'b0;
      #3;
      if (inst_addr_ok || data_addr_ok) begin
        expData = (grants % 2 == 0);
        chk($sformatf("contention_side%0d", grants), data_addr_ok, expData);
        chk($sformatf("contention_addr%0d", grants), mem_addr,
            expData ? 32'h8000_0100 : 32'hBFC0_0000);
        grants++;
        pendData = 1'b1;
      end
      step();
    end
    chk("contention_grants", grants, 4);
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = pendData;
    step();
    applyIdle();
    #3;
    chk("contention_protocol_err", protocol_err, 1'b0);
    step();
  endtask

  task automatic runFlushWait();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    #3; chk("fw_inst_on_req", inst_on, 1'b1); step();
    mem_addr_ok = 1'b1;
    #3; chk("fw_inst_addr_ok", inst_addr_ok, 1'b1); chk("fw_mem_addr", mem_addr, 32'hBFC0_0000); step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; inst_flush = 1'b1;
    #3; chk("fw_inst_on_flush", inst_on, 1'b0); step();
    inst_flush = 1'b0;
    #3; chk("fw_inst_on_discard", inst_on, 1'b0); step();
    mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
    #3; chk("fw_inst_data_ok_killed", inst_data_ok, 1'b0); chk("fw_inst_rdata_killed", inst_rdata, 32'h0); step();
    mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    #3; chk("fw_mem_req_idle", mem_req, 1'b0); step();
    mem_addr_ok = 1'b1;
    #3; chk("fw_next_addr", mem_addr, 32'hBFC0_0004); chk("fw_next_addr_ok", inst_addr_ok, 1'b1); step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #3;
    chk("fw_next_data_ok", inst_data_ok, 1'b1);
    chk("fw_next_rdata", inst_rdata, 32'hCAFE_F00D);
    chk("fw_next_inst_on", inst_on, 1'b0);
    step();
    applyIdle();
  endtask

  task automatic runFlushAddr();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    #3; chk("fa_mem_req_c0", mem_req, 1'b0); step();
    inst_flush = 1'b1;
    #3; chk("fa_mem_req_flush", mem_req, 1'b1); chk("fa_addr_ok", inst_addr_ok, 1'b0); chk("fa_inst_on", inst_on, 1'b0); step();
    inst_req = 1'b0; inst_flush = 1'b0;
    #3; chk("fa_mem_req_dropped", mem_req, 1'b0); step();
    data_req = 1'b1; data_addr = 32'h8000_0200; data_size = 2'd2;
    #3; chk("fa_idle_again", mem_req, 1'b0); step();
    mem_addr_ok = 1'b1;
    #3; chk("fa_data_addr", mem_addr, 32'h8000_0200); chk("fa_data_addr_ok", data_addr_ok, 1'b1); step();
    data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    #3; chk("fa_data_data_ok", data_data_ok, 1'b1); chk("fa_no_inst_data", inst_data_ok, 1'b0); step();
    applyIdle();
    #3; chk("fa_protocol_err", protocol_err, 1'b0); step();
  endtask

  // Transaction-level model: the port is either free or owned by one side, whose address is
  // either still being offered or already accepted; ties alternate starting with data.
  task automatic runRandom(input int n);
    bit busy = 0, ownData = 0, accepted = 0, killed = 0, preferData = 1, err = 0;
    bit iHold = 0, dHold = 0;
    logic [31:0] iA = '0, dA = '0, dW = '0;
    logic        dWrR = 1'b0;
    logic [1:0]  dSz = 2'd0;
    bit liveInst, addrPh, dataPh, eIAok, eDAok, eIDok, eDDok, eIOn, eDOn;
    for (int c = 0; c < n; c++) begin
      inst_flush = ($urandom_range(0, 11) == 0);
      if (!iHold && $urandom_range(0, 2) == 0) begin
        iHold = 1; iA = $urandom; iA[1:0] = 2'b00;
      end
      if (!dHold && $urandom_range(0, 2) == 0) begin
        dHold = 1; dA = $urandom; dW = $urandom; dWrR = 1'($urandom_range(0, 1));
        dSz = 2'($urandom_range(0, 2));
      end
      inst_req = iHold; inst_addr = iA;
      data_req = dHold; data_addr = dA; data_wdata = dW; data_wr = dWrR; data_size = dSz;
      mem_addr_ok = busy && !accepted && ($urandom_range(0, 2) != 0);
      if (busy && accepted) mem_data_ok = ($urandom_range(0, 2) == 0);
      else mem_data_ok = (c > n - 400) && ($urandom_range(0, 49) == 0);
      mem_rdata = $urandom;
      #3;
      liveInst = inst_req && !inst_flush;
      addrPh = busy && !accepted;
      dataPh = busy && accepted;
      eIAok = addrPh && !ownData && mem_addr_ok;
      eDAok = addrPh && ownData && mem_addr_ok;
      eIDok = dataPh && !ownData && mem_data_ok && !killed && !inst_flush;
      eDDok = dataPh && ownData && mem_data_ok;
      eIOn  = !inst_flush && !eIDok && (inst_req || (busy && !ownData && !killed));
      eDOn  = !eDDok && (data_req || (busy && ownData));
      chk("rnd_mem_req", mem_req, addrPh);
      chk("rnd_mem_addr", mem_addr, addrPh ? (ownData ? dA : iA) : 32'h0);
      chk("rnd_mem_wr", mem_wr, addrPh && ownData && dWrR);
      chk("rnd_mem_size", mem_size, addrPh ? (ownData ? dSz : 2'd2) : 2'd0);
      chk("rnd_mem_wdata", mem_wdata, (addrPh && ownData) ? dW : 32'h0);
      chk("rnd_inst_addr_ok", inst_addr_ok, eIAok);
      chk("rnd_data_addr_ok", data_addr_ok, eDAok);
      chk("rnd_inst_data_ok", inst_data_ok, eIDok);
      chk("rnd_data_data_ok", data_data_ok, eDDok);
      chk("rnd_inst_rdata", inst_rdata, eIDok ? mem_rdata : 32'h0);
      chk("rnd_data_rdata", data_rdata, eDDok ? mem_rdata : 32'h0);
      chk("rnd_inst_on", inst_on, eIOn);
      chk("rnd_data_on", data_on, eDOn);
      chk("rnd_protocol_err", protocol_err, err);
      if (mem_data_ok && !dataPh) err = 1;
      if (!busy) begin
        if (data_req && liveInst) begin busy = 1; ownData = preferData; end
        else if (data_req) begin busy = 1; ownData = 1; end
        else if (liveInst) begin busy = 1; ownData = 0; end
        accepted = 0; killed = 0;
      end else if (!accepted) begin
        if (mem_addr_ok) begin
          accepted = 1; killed = !ownData && inst_flush; preferData = !ownData;
        end else if (!ownData && inst_flush) begin
          busy = 0;
        end
      end else begin
        if (mem_data_ok) begin busy = 0; killed = 0; end
        else if (!ownData && inst_flush) killed = 1;
      end
      if (eIAok || inst_flush) iHold = 0;
      if (eDAok) dHold = 0;
      step();
    end
    applyIdle();
  endtask

  initial begin
    applyIdle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #3;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_protocol_err", protocol_err, 1'b0);
    chk("reset_inst_on", inst_on, 1'b0);
    chk("reset_data_on", data_on, 1'b0);
    step();
    runTable();
    doReset();
    runContention();
    doReset();
    runFlushWait();
    doReset();
    runFlushAddr();
    doReset();
    runRandom(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
